// File: rtl/controle_polinomio.sv
// -----------------------------------------------------------------------------
// controle_polinomio
// Control block for the 16-bit polynomial datapath (Reg_X/Reg_S/Reg_H, operand
// muxes m0/m1/m2, add/multiply unit). Accepts a start/op request in IDLE and
// sequences load enables, mux selects and ALU opcode until Reg_S holds:
//   op 00 : A*X^2 + B*X + C  (Horner: ((A*X)+B)*X + C)
//   op 01 : A*X + B
//   op 10 : A*X^2 + C        (H = X*X, S = A*H + C)
//   op 11 : reserved, start ignored
//
// Ports
//   ck        in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request, sampled only in IDLE
//   op[1:0]   in   operation select
//   lx        out  load Reg_X from input X
//   m0[1:0]   out  constant mux: 00 zero, 01 A, 10 B, 11 C
//   m1[1:0]   out  ALU port 1: 00 m0-out, 01 Reg_X, 10 Reg_S, 11 Reg_H
//   m2[1:0]   out  ALU port 2: 00 Reg_X, 01 m0-out, 10 Reg_S, 11 Reg_H
//   h         out  ALU op: 0 add, 1 multiply
//   ls        out  load Reg_S from ALU
//   lh        out  load Reg_H from ALU
//   done      out  one-cycle pulse, result valid in Reg_S
//   busy      out  high in every state except IDLE
//   op_count  out  completed-operation counter (only with CTRL_OP_COUNT_EN)
//
// Optional feature macro: CTRL_OP_COUNT_EN adds the op_count port and counter.
//
// Moore machine: every output is decoded from the state register and the
// latched op only, so there is no combinational path from start/op.
// -----------------------------------------------------------------------------
module controle_polinomio (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       done,
    output logic       busy
`ifdef CTRL_OP_COUNT_EN
    ,
    output logic [7:0] op_count
`endif
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned SEL_W = 2;
`ifdef CTRL_OP_COUNT_EN
    localparam int unsigned CNT_W = 8;
`endif

    // Operation codes
    localparam logic [OP_W-1:0] OP_QUAD = 2'b00;
    localparam logic [OP_W-1:0] OP_LIN  = 2'b01;
    localparam logic [OP_W-1:0] OP_SQH  = 2'b10;
    localparam logic [OP_W-1:0] OP_RSV  = 2'b11;

    // Constant mux selects
    localparam logic [SEL_W-1:0] M0_ZERO = 2'b00;
    localparam logic [SEL_W-1:0] M0_A    = 2'b01;
    localparam logic [SEL_W-1:0] M0_B    = 2'b10;
    localparam logic [SEL_W-1:0] M0_C    = 2'b11;

    // ALU port 1 selects
    localparam logic [SEL_W-1:0] P1_M0 = 2'b00;
    localparam logic [SEL_W-1:0] P1_X  = 2'b01;
    localparam logic [SEL_W-1:0] P1_S  = 2'b10;

    // ALU port 2 selects
    localparam logic [SEL_W-1:0] P2_X  = 2'b00;
    localparam logic [SEL_W-1:0] P2_M0 = 2'b01;
    localparam logic [SEL_W-1:0] P2_H  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQ   = 3'd2,
        S_MUL1 = 3'd3,
        S_ADD1 = 3'd4,
        S_MUL2 = 3'd5,
        S_ADD2 = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [OP_W-1:0] op_q;
    logic            accept;

    // A request is taken only from IDLE and never for the reserved code
    assign accept = (state == S_IDLE) && start && (op != OP_RSV);

    // State register
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latched operation, captured on the accepting edge and held until IDLE
    always_ff @(posedge ck) begin
        if (rst) begin
            op_q <= OP_QUAD;
        end else if (accept) begin
            op_q <= op;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = (op_q == OP_SQH) ? S_SQ : S_MUL1;
            end
            S_SQ: begin
                state_nx = S_MUL1;
            end
            S_MUL1: begin
                state_nx = (op_q == OP_SQH) ? S_ADD2 : S_ADD1;
            end
            S_ADD1: begin
                state_nx = (op_q == OP_LIN) ? S_DONE : S_MUL2;
            end
            S_MUL2: begin
                state_nx = S_ADD2;
            end
            S_ADD2: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output decode: everything idle by default, each state drives what it uses
    always_comb begin
        lx   = 1'b0;
        m0   = M0_ZERO;
        m1   = P1_M0;
        m2   = P2_X;
        h    = 1'b0;
        ls   = 1'b0;
        lh   = 1'b0;
        done = 1'b0;
        busy = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
            end
            S_LOAD: begin
                lx = 1'b1;
            end
            S_SQ: begin
                // H = X * X
                m1 = P1_X;
                m2 = P2_X;
                h  = 1'b1;
                lh = 1'b1;
            end
            S_MUL1: begin
                // S = A * X, or S = A * H for the squared form
                m0 = M0_A;
                m1 = P1_M0;
                m2 = (op_q == OP_SQH) ? P2_H : P2_X;
                h  = 1'b1;
                ls = 1'b1;
            end
            S_ADD1: begin
                // S = S + B
                m0 = M0_B;
                m1 = P1_S;
                m2 = P2_M0;
                ls = 1'b1;
            end
            S_MUL2: begin
                // S = S * X
                m1 = P1_S;
                m2 = P2_X;
                h  = 1'b1;
                ls = 1'b1;
            end
            S_ADD2: begin
                // S = S + C
                m0 = M0_C;
                m1 = P1_S;
                m2 = P2_M0;
                ls = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef CTRL_OP_COUNT_EN
    // Completed-operation counter, wraps naturally at 2^CNT_W
    always_ff @(posedge ck) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == S_DONE) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_controle_polinomio.sv
// -----------------------------------------------------------------------------
// tb_controle_polinomio
// Self-checking bench for controle_polinomio. A small behavioural model of the
// 16-bit datapath (Reg_X/S/H, muxes, add/multiply) follows the controller's
// outputs so that final Reg_S/Reg_H values can be compared against hand-computed
// polynomial results. Table-driven vectors cover the three operations; hand
// sequences cover control-word ordering, reserved op, start while busy, reset
// mid-operation, rst/start collision and back-to-back requests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controle_polinomio;

    logic       ck = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       lx, h, ls, lh, done, busy;
    logic [1:0] m0, m1, m2;
`ifdef CTRL_OP_COUNT_EN
    logic [7:0] op_count;
`endif

    always #5 ck = ~ck;

    controle_polinomio dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .op    (op),
        .lx    (lx),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .h     (h),
        .ls    (ls),
        .lh    (lh),
        .done  (done),
        .busy  (busy)
`ifdef CTRL_OP_COUNT_EN
        ,
        .op_count (op_count)
`endif
    );

    // Behavioural datapath driven by the controller outputs
    logic [15:0] a_in, b_in, c_in, x_in;
    logic [15:0] rx, rs, rh;
    logic [15:0] m0o, p1, p2, alu;

    always_comb begin
        m0o = 16'd0;
        p1  = 16'd0;
        p2  = 16'd0;
        case (m0)
            2'b00: m0o = 16'd0;
            2'b01: m0o = a_in;
            2'b10: m0o = b_in;
            default: m0o = c_in;
        endcase
        case (m1)
            2'b00: p1 = m0o;
            2'b01: p1 = rx;
            2'b10: p1 = rs;
            default: p1 = rh;
        endcase
        case (m2)
            2'b00: p2 = rx;
            2'b01: p2 = m0o;
            2'b10: p2 = rs;
            default: p2 = rh;
        endcase
        alu = h ? 16'(p1 * p2) : 16'(p1 + p2);
    end

    always @(posedge ck) begin
        if (lx) rx <= x_in;
        if (ls) rs <= alu;
        if (lh) rh <= alu;
    end

    // {lx, m0, m1, m2, h, ls, lh, done, busy}
    logic [11:0] ctrl_w;
    assign ctrl_w = {lx, m0, m1, m2, h, ls, lh, done, busy};

    localparam logic [11:0] W_IDLE  = 12'b0_00_00_00_0_0_0_0_0;
    localparam logic [11:0] W_LOAD  = 12'b1_00_00_00_0_0_0_0_1;
    localparam logic [11:0] W_SQ    = 12'b0_00_01_00_1_0_1_0_1;
    localparam logic [11:0] W_MUL1  = 12'b0_01_00_00_1_1_0_0_1;
    localparam logic [11:0] W_MUL1H = 12'b0_01_00_11_1_1_0_0_1;
    localparam logic [11:0] W_ADD1  = 12'b0_10_10_01_0_1_0_0_1;
    localparam logic [11:0] W_MUL2  = 12'b0_00_10_00_1_1_0_0_1;
    localparam logic [11:0] W_ADD2  = 12'b0_11_10_01_0_1_0_0_1;
    localparam logic [11:0] W_DONE  = 12'b0_00_00_00_0_0_0_1_1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b, c, x;
        int          done_cyc;
        logic [15:0] exp_s;
        logic [15:0] exp_h;
        bit          chk_h;
    } vec_t;

    vec_t vecs[6];

    // One request from IDLE; checks done cycle, Reg_S, optional Reg_H, busy drop
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] x,
                          input int exp_cyc, input logic [15:0] exp_s,
                          input logic [15:0] exp_h, input bit chk_h);
        int cyc;
        a_in = a; b_in = b; c_in = c; x_in = x;
        op = o; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({name, " done_cycle"}, cyc, exp_cyc);
        check({name, " reg_s"}, int'(rs), int'(exp_s));
        if (chk_h) check({name, " reg_h"}, int'(rh), int'(exp_h));
        tick();
        check({name, " idle_after"}, int'({busy, done}), 0);
    endtask

    // Applies one request and compares the control word every cycle
    task automatic seq_check(input string name, input logic [1:0] o,
                             input logic [11:0] exp_w[8], input int n);
        op = o; start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            check($sformatf("%s word%0d", name, i + 1), int'(ctrl_w), int'(exp_w[i]));
        end
    endtask

    // Holds start high for n acceptances; checks first done cycle and spacing
    task automatic b2b(input string name, input logic [1:0] o, input int n,
                       input int period, input int first);
        int dn, last, bad;
        dn = 0; last = 0; bad = 0;
        op = o; start = 1'b1;
        for (int cyc = 1; cyc <= n * period + 10 && dn < n; cyc++) begin
            tick();
            if (done) begin
                dn++;
                if (dn == 1) begin
                    if (cyc != first) bad++;
                end else if (cyc - last != period) begin
                    bad++;
                end
                last = cyc;
                if (dn == n) start = 1'b0;
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dn++;
        end
        check({name, " done_count"}, dn, n);
        check({name, " timing_errors"}, bad, 0);
    endtask

    logic [11:0] seq00[8];
    logic [11:0] seq10[8];

    initial begin
        vecs[0] = '{2'b00, 16'd2,     16'd3, 16'd4, 16'd5,   6, 16'd69,    16'd0,     1'b0};
        vecs[1] = '{2'b01, 16'd3,     16'd7, 16'd0, 16'd10,  4, 16'd37,    16'd0,     1'b0};
        vecs[2] = '{2'b10, 16'd2,     16'd0, 16'd1, 16'd300, 5, 16'd48929, 16'd24464, 1'b1};
        vecs[3] = '{2'b00, 16'd1000,  16'd7, 16'd9, 16'd300, 6, 16'd21181, 16'd0,     1'b0};
        vecs[4] = '{2'b01, 16'd65535, 16'd2, 16'd0, 16'd1,   4, 16'd1,     16'd0,     1'b0};
        vecs[5] = '{2'b10, 16'd3,     16'd0, 16'd5, 16'd4,   5, 16'd53,    16'd16,    1'b1};

        seq00 = '{W_LOAD, W_MUL1, W_ADD1, W_MUL2, W_ADD2, W_DONE, W_IDLE, W_IDLE};
        seq10 = '{W_LOAD, W_SQ, W_MUL1H, W_ADD2, W_DONE, W_IDLE, W_IDLE, W_IDLE};

        rst = 1'b1; start = 1'b0; op = 2'b00;
        a_in = '0; b_in = '0; c_in = '0; x_in = '0;

        // Reset
        tick();
        tick();
        check("reset ctrl_word", int'(ctrl_w), 0);
`ifdef CTRL_OP_COUNT_EN
        check("reset op_count", int'(op_count), 0);
`endif
        rst = 1'b0;
        tick();

        // Control-word sequences
        a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 16'd5;
        seq_check("seq op00", 2'b00, seq00, 7);
        check("seq op00 reg_s", int'(rs), 69);
        a_in = 16'd2; c_in = 16'd1; x_in = 16'd300;
        seq_check("seq op10", 2'b10, seq10, 6);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].c, vecs[i].x, vecs[i].done_cyc, vecs[i].exp_s,
                   vecs[i].exp_h, vecs[i].chk_h);
        end

        // Reserved op: start ignored
        begin
            int seen;
            seen = 0;
            op = 2'b11; start = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (busy || done) seen++;
            end
            start = 1'b0;
            check("op11 ignored", seen, 0);
        end

        // start pulsed while busy: single done, original op result
        begin
            int dn, dcyc;
            dn = 0; dcyc = 0;
            a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 16'd5;
            op = 2'b00; start = 1'b1;
            tick();
            start = 1'b0;
            for (int cyc = 1; cyc <= 14; cyc++) begin
                if (cyc == 3) begin op = 2'b01; start = 1'b1; end
                if (cyc == 4) start = 1'b0;
                if (done) begin dn++; dcyc = cyc; end
                if (cyc == 6) check("busy start reg_s", int'(rs), 69);
                tick();
            end
            check("busy start done_count", dn, 1);
            check("busy start done_cycle", dcyc, 6);
        end

        // rst in cycle 3 of op00
        begin
            int dn;
            dn = 0;
            op = 2'b00; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            rst = 1'b1;
            tick();
            check("mid rst ctrl_word", int'(ctrl_w), 0);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (done || busy) dn++;
            end
            check("mid rst no activity", dn, 0);
            run_op("after rst op01", 2'b01, 16'd3, 16'd7, 16'd0, 16'd10,
                   4, 16'd37, 16'd0, 1'b0);
        end

        // rst and start in the same cycle: rst wins
        rst = 1'b1; op = 2'b00; start = 1'b1;
        tick();
        check("rst vs start", int'(ctrl_w), 0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Back-to-back requests
        a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 16'd5;
        b2b("b2b op00", 2'b00, 3, 7, 6);
        check("b2b op00 reg_s", int'(rs), 69);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2b("b2b op01 x257", 2'b01, 257, 5, 4);
`ifdef CTRL_OP_COUNT_EN
        check("op_count wrap", int'(op_count), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
